// File: rtl/lane_input_decoder.sv
// Keycode-to-fret-lane decoder: two-flop keycode sync, per-lane debounce
// qualification, same-lane re-press lockout, and a frame-tick hold counter.
// 'release' is a reserved word, so the release pulse port is release_pulse.

// Per-lane output cell: registers the one-cycle press/release events and
// keeps the held level consistent with them.
module lane_out_cell (
    input  logic Clk,
    input  logic Reset,
    input  logic press_evt,
    input  logic rls_evt,
    output logic press,
    output logic rls,
    output logic held
);
    // held rises with the press pulse and falls with the release pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            press <= 1'b0;
            rls   <= 1'b0;
            held  <= 1'b0;
        end else begin
            press <= press_evt;
            rls   <= rls_evt;
            if (press_evt)
                held <= 1'b1;
            else if (rls_evt)
                held <= 1'b0;
        end
    end
endmodule

module lane_input_decoder #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  LOCKOUT_FRAMES  = 8'd4,
    parameter logic [7:0]  KEY_G           = 8'h04,
    parameter logic [7:0]  KEY_R           = 8'h16,
    parameter logic [7:0]  KEY_Y           = 8'h07,
    parameter logic [7:0]  KEY_B           = 8'h09,
    parameter logic [7:0]  KEY_O           = 8'h0A
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [4:0] press,
    output logic [4:0] release_pulse,
    output logic [4:0] held,
    output logic [2:0] active_lane,
    output logic [7:0] hold_frames
);
    localparam int          NUM_LANES = 5;
    localparam logic [2:0]  NONE      = 3'd7;
    localparam logic [15:0] DEB_MAX   = DEBOUNCE_CYCLES - 16'd1;

    typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

    state_t         state, state_nxt;
    logic [7:0]     k1, k2;
    logic           fs1, fs2, fprev, tick;
    logic [2:0]     cand, cand_prev;
    logic [15:0]    stab_cnt;
    logic           stable;
    logic [2:0]     lock_lane;
    logic [7:0]     lock_cnt;
    logic           locked;
    logic           do_press, do_release, arm;
    logic [NUM_LANES-1:0] press_evt, rls_evt;

    // Keycode and frame_clk synchronisers plus frame edge register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            k1    <= 8'h00;
            k2    <= 8'h00;
            fs1   <= 1'b0;
            fs2   <= 1'b0;
            fprev <= 1'b0;
        end else begin
            k1    <= keycode;
            k2    <= k1;
            fs1   <= frame_clk;
            fs2   <= fs1;
            fprev <= fs2;
        end
    end

    assign tick = fs2 & ~fprev;

    // Map the synchronised keycode to a lane index, NONE when unmapped
    always_comb begin
        cand = NONE;
        case (k2)
            KEY_G:   cand = 3'd0;
            KEY_R:   cand = 3'd1;
            KEY_Y:   cand = 3'd2;
            KEY_B:   cand = 3'd3;
            KEY_O:   cand = 3'd4;
            default: cand = NONE;
        endcase
    end

    // Stability counter: restarts on any candidate change, holds at the top
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cand_prev <= NONE;
            stab_cnt  <= 16'd0;
        end else begin
            cand_prev <= cand;
            if (cand != cand_prev)
                stab_cnt <= 16'd0;
            else if (stab_cnt != DEB_MAX)
                stab_cnt <= stab_cnt + 16'd1;
        end
    end

    // The change cycle itself never counts as stable, even with a saturated
    // counter, so a fresh key cannot release a held lane prematurely.
    assign stable = (stab_cnt == DEB_MAX) && (cand == cand_prev);

    // Lockout: single lane slot with a frame down-counter; arming wins over tick
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lock_lane <= NONE;
            lock_cnt  <= 8'd0;
        end else if (arm) begin
            lock_lane <= active_lane;
            lock_cnt  <= LOCKOUT_FRAMES;
        end else if (tick && lock_cnt != 8'd0) begin
            lock_cnt  <= lock_cnt - 8'd1;
        end
    end

    assign locked = (lock_cnt != 8'd0) && (lock_lane == cand);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state and press/release/arm decisions
    always_comb begin
        state_nxt  = state;
        do_press   = 1'b0;
        do_release = 1'b0;
        arm        = 1'b0;
        case (state)
            IDLE: begin
                if (cand != NONE)
                    state_nxt = QUAL;
            end
            QUAL: begin
                if (cand == NONE) begin
                    state_nxt = IDLE;
                end else if (stable && !locked) begin
                    do_press  = 1'b1;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (cand != active_lane && stable) begin
                    do_release = 1'b1;
                    arm        = 1'b1;
                    state_nxt  = (cand != NONE) ? QUAL : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-hot event vectors for the lane cells
    always_comb begin
        press_evt = '0;
        rls_evt   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            press_evt[i] = do_press   && (cand == 3'(i));
            rls_evt[i]   = do_release && (active_lane == 3'(i));
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_out_cell u_cell (
            .Clk       (Clk),
            .Reset     (Reset),
            .press_evt (press_evt[i]),
            .rls_evt   (rls_evt[i]),
            .press     (press[i]),
            .rls       (release_pulse[i]),
            .held      (held[i])
        );
    end

    // Active lane index and saturating frame counter for the held lane
    always_ff @(posedge Clk) begin
        if (Reset) begin
            active_lane <= NONE;
            hold_frames <= 8'd0;
        end else if (do_press) begin
            active_lane <= cand;
            hold_frames <= 8'd0;
        end else if (do_release) begin
            active_lane <= NONE;
            hold_frames <= 8'd0;
        end else if (state == HELD && tick && hold_frames != 8'hFF) begin
            hold_frames <= hold_frames + 8'd1;
        end
    end
endmodule
